ptmch_spi_mst: RTL and testbench

PTMCH_SPI_MST -- requirements
Module: ptmch_spi_mst

---
 rtl/ptmch_spi_mst.sv | 129 ++++++++++++
 tb/tb_ptmch_spi_mst.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ptmch_spi_mst.sv
// SPI mode-0 master: one DATA_W-bit frame per accept, MSB first, with CS setup/hold/gap timing.
// Define PTMCH_SPI_PARITY_EN to append an odd-parity bit after the LSB.
module ptmch_spi_mst #(
    parameter int DATA_W   = 16,
    parameter int CLK_DIV  = 10,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 4
) (
    input  logic              CLK200M,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    output logic              BUSY,
    output logic              DONE,
    output logic              SPI_CS,
    output logic              SPI_CLK,
    output logic              SPI_MOSI
);

`ifdef PTMCH_SPI_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int CNT_W = 16;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(NBITS + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [NBITS-2:0]   shreg;     // bits still to send; the current bit lives in SPI_MOSI
    logic [NBITS-1:0]   load_val;

`ifdef PTMCH_SPI_PARITY_EN
    assign load_val = {TX_DATA, ~^TX_DATA};
`else
    assign load_val = TX_DATA;
`endif

    always_ff @(posedge CLK200M or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            cnt      <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            TX_READY <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            SPI_CS   <= 1'b1;
            SPI_CLK  <= 1'b0;
            SPI_MOSI <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    TX_READY <= 1'b1;
                    if (TX_VALID && TX_READY) begin
                        shreg    <= load_val[NBITS-2:0];
                        SPI_MOSI <= load_val[NBITS-1];
                        SPI_CS   <= 1'b0;
                        BUSY     <= 1'b1;
                        TX_READY <= 1'b0;
                        cnt      <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == CNT_W'(CS_SETUP - 1)) begin
                        cnt     <= '0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        SPI_CLK <= ~SPI_CLK;
                        // Falling edge: advance to next bit, or finish after the last one
                        if (SPI_CLK) begin
                            if (bit_cnt == BIT_W'(NBITS - 1)) begin
                                bit_cnt <= '0;
                                state   <= HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                SPI_MOSI <= shreg[NBITS-2];
                                shreg    <= {shreg[NBITS-3:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == CNT_W'(CS_HOLD - 1)) begin
                        cnt      <= '0;
                        SPI_CS   <= 1'b1;
                        SPI_MOSI <= 1'b0;
                        DONE     <= 1'b1;
                        state    <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(CS_GAP - 1)) begin
                        cnt      <= '0;
                        BUSY     <= 1'b0;
                        TX_READY <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ptmch_spi_mst.sv
// Randomized bench for ptmch_spi_mst: a line-level monitor rebuilds each frame and
// checks it against the queue of accepted payloads and the frame timing rules.
`timescale 1ns/1ps
module tb_ptmch_spi_mst;
    localparam int DATA_W = 16, CLK_DIV = 10, CS_SETUP = 4, CS_HOLD = 4, CS_GAP = 4;
`ifdef PTMCH_SPI_PARITY_EN
    localparam int NB = DATA_W + 1;
`else
    localparam int NB = DATA_W;
`endif
    localparam int CS_LEN = CS_SETUP + 2 * NB * CLK_DIV + CS_HOLD;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready, busy, done, spi_cs, spi_clk, spi_mosi;

    always #5 clk = ~clk;

    ptmch_spi_mst #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP),
                    .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
        .CLK200M(clk), .RESET_N(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid),
        .TX_READY(tx_ready), .BUSY(busy), .DONE(done), .SPI_CS(spi_cs),
        .SPI_CLK(spi_clk), .SPI_MOSI(spi_mosi));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    // Expected on-wire bit sequence for one payload, first bit in the MSB position
    function automatic logic [32:0] frame_bits(input logic [DATA_W-1:0] d);
`ifdef PTMCH_SPI_PARITY_EN
        return 33'({d, ~^d});
`else
        return 33'(d);
`endif
    endfunction

    // ---------------- monitor ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_d;
    logic [32:0]       bits;
    int  cyc = 0, acc_cyc = 0, rise_cyc = -1000, nrise = 0, cs_len = 0;
    logic p_cs = 1'b1, p_clk = 1'b0, p_mosi = 1'b0, p_rise = 1'b0, rise;
    logic mosi_bad = 1'b0, rdy_bad = 1'b0, idle_bad = 1'b0, in_frame = 1'b0, b2b = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            in_frame = 1'b0; idle_bad = 1'b0;
            p_cs = 1'b1; p_clk = 1'b0; p_mosi = 1'b0; p_rise = 1'b0;
        end else begin
            rise = spi_clk && !p_clk;
            if (tx_valid && tx_ready) begin
                exp_q.push_back(tx_data);
                acc_cyc = cyc;
            end
            if (p_cs && !spi_cs) begin
                chk("cs_fall_lat", 64'(cyc - acc_cyc), 64'd1);
                chk("idle_lines", 64'(idle_bad), 64'd0);
                if (b2b) chk("b2b_gap", 64'(cyc - rise_cyc), 64'(CS_GAP + 1));
                else     chk("gap_min", 64'((cyc - rise_cyc) >= CS_GAP + 1), 64'd1);
                idle_bad = 1'b0; in_frame = 1'b1;
                bits = '0; nrise = 0; cs_len = 0; mosi_bad = 1'b0; rdy_bad = 1'b0;
            end
            if (!spi_cs) begin
                cs_len++;
                if (rise) begin
                    bits = {bits[31:0], spi_mosi};
                    nrise++;
                end
                if ((rise || p_rise) && spi_mosi !== p_mosi) mosi_bad = 1'b1;
                if (tx_ready || !busy) rdy_bad = 1'b1;
            end else if (spi_clk || spi_mosi) begin
                idle_bad = 1'b1;
            end
            if (!p_cs && spi_cs && in_frame) begin
                rise_cyc = cyc; in_frame = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("frame_unexpected", 64'd0, 64'd1);
                end else begin
                    m_d = exp_q.pop_front();
                    chk("bits", 64'(bits), 64'(frame_bits(m_d)));
                end
                chk("nrise", 64'(nrise), 64'(NB));
                chk("cs_len", 64'(cs_len), 64'(CS_LEN));
                chk("mosi_stable", 64'(mosi_bad), 64'd0);
                chk("busy_ready", 64'(rdy_bad), 64'd0);
            end
            if (done || (!p_cs && spi_cs)) chk("done", 64'(done), 64'(!p_cs && spi_cs));
            p_cs = spi_cs; p_clk = spi_clk; p_mosi = spi_mosi; p_rise = rise;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 5000) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input bit dead_pulse);
        wait_ready();
        tx_valid = 1'b1; tx_data = d;
        @(posedge clk); #1;
        tx_valid = 1'b0; tx_data = DATA_W'($urandom);
        if (dead_pulse) begin
            repeat ($urandom_range(20, 200)) @(posedge clk);
            #1; tx_valid = 1'b1; tx_data = 16'hDEAD;
            repeat (3) @(posedge clk);
            #1; tx_valid = 1'b0;
        end
        wait_ready();
        repeat ($urandom_range(0, 8)) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_lines();
        chk("rst_cs", 64'(spi_cs), 64'd1);
        chk("rst_clk", 64'(spi_clk), 64'd0);
        chk("rst_mosi", 64'(spi_mosi), 64'd0);
        chk("rst_ready", 64'(tx_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
    endtask

    initial begin
        int n, hi;
        repeat (3) @(posedge clk);
        #1 check_reset_lines();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 chk("ready_after_rst", 64'(tx_ready), 64'd1);

        send(16'hA55A, 1'b0);

        // TX_VALID held high across two frames
        wait_ready();
        tx_valid = 1'b1; tx_data = 16'h0001;
        @(posedge clk); #1;
        @(negedge clk); #1;
        b2b = 1'b1; tx_data = 16'hFFFF;
        n = 0;
        while (!tx_ready && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1 tx_valid = 1'b0;
        @(negedge clk); #1 b2b = 1'b0;
        wait_ready();

        send(16'h00FF, 1'b1);

        // Reset in the middle of a frame, at the 100th SPI_CLK-high cycle
        wait_ready();
        tx_valid = 1'b1; tx_data = DATA_W'($urandom);
        @(posedge clk); #1 tx_valid = 1'b0;
        n = 0; hi = 0;
        while (hi < 100 && n < 10000) begin
            @(negedge clk); n++;
            if (spi_clk) hi++;
        end
        chk("reach_100_high", 64'(hi), 64'd100);
        #1 rst_n = 1'b0;
        #1 check_reset_lines();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 chk("ready_after_abort", 64'(tx_ready), 64'd1);
        send(16'h1234, 1'b0);

`ifdef PTMCH_SPI_PARITY_EN
        send(16'h0003, 1'b0);
        send(16'h0007, 1'b0);
`endif
        for (int i = 0; i < 12; i++) send(DATA_W'($urandom), 1'($urandom_range(0, 1)));

        wait_ready();
        repeat (10) @(posedge clk);
        #1 chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
